// File: rtl/serial_csa_controller.sv
// serial_csa_controller
//   Adds two W-bit operands (W = 4*NIBBLES) plus a carry-in, one 4-bit
//   nibble per clock, through a single shared carry-select adder slice.
//   The final sum and carry-out are published on the edge that enters the
//   DONE state and hold until the next completion.
//
// Ports
//   clk    in   clock, all state on the rising edge
//   rst    in   synchronous active-high reset
//   start  in   request pulse, accepted in IDLE and DONE, ignored in RUN
//   a, b   in   W-bit operands, captured on an accepted start
//   cin    in   carry-in, captured on an accepted start
//   busy   out  high while nibbles are being processed (RUN)
//   done   out  one-cycle completion pulse (DONE)
//   sum    out  registered (a + b + cin) mod 2^W
//   cout   out  registered carry out of bit W-1
module serial_csa_controller #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int              IW   = $clog2(NIBBLES);
    localparam logic [IW-1:0]   LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic [W-1:0]    psum;
    logic            carry;
    logic [IW-1:0]   idx;

    logic [4:0]      slice;
    logic [W-1:0]    psum_next;
    logic            accept;

    // Carry-select slice: both carry-in cases are formed in parallel and the
    // incoming carry only drives the final mux.
    function automatic logic [4:0] csa_slice(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       ci);
        logic [4:0] s0;
        logic [4:0] s1;
        s0 = {1'b0, x} + {1'b0, y};
        s1 = {1'b0, x} + {1'b0, y} + 5'd1;
        return ci ? s1 : s0;
    endfunction

    always_comb begin
        slice     = csa_slice(opa[{idx, 2'b00} +: 4], opb[{idx, 2'b00} +: 4], carry);
        psum_next = psum;
        psum_next[{idx, 2'b00} +: 4] = slice[3:0];
    end

    assign accept = start && (state != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                RUN: begin
                    psum  <= psum_next;
                    carry <= slice[4];
                    if (idx == LAST) begin
                        // Final nibble: publish the completed result directly
                        // from the combinational partial so it is not a cycle late.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= psum_next;
                        cout  <= slice[4];
                        idx   <= '0;
                    end else begin
                        idx   <= idx + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE otherwise
                    // falls back to IDLE after its single cycle.
                    done <= 1'b0;
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        idx   <= '0;
                        psum  <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_csa_controller.sv
module tb_serial_csa_controller;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    serial_csa_controller #(.NIBBLES(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic         rst_q = 1'b1;
    logic [W-1:0] last_sum = '0;
    logic         last_cout = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and also watches the
    // output-hold and busy/done exclusivity rules every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1 && done === 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_done_overlap: busy=1 done=1, expected never both (cycle %0d)", cyc);
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.s));
                check("cout", 32'(cout), 32'(e.c));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (rst_q !== 1'b1) begin
            check("sum_hold", 32'(sum), 32'(last_sum));
            check("cout_hold", 32'(cout), 32'(last_cout));
        end
        last_sum  = sum;
        last_cout = cout;
    end

    function automatic exp_t mk(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic ci, input int at);
        exp_t e;
        logic [W:0] r;
        r     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s   = r[W-1:0];
        e.c   = r[W];
        e.cyc = at;
        return e;
    endfunction

    // Issue one request at a falling edge; 'hold' extra cycles follow the
    // start pulse (N-1 lets the next request land in DONE, back-to-back).
    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input int hold);
        @(negedge clk);
        a = x; b = y; cin = ci; start = 1'b1;
        sb.push_back(mk(x, y, ci, cyc + 1 + N));
        @(negedge clk);
        start = 1'b0;
        repeat (hold) @(negedge clk);
    endtask

    // Directed vectors: operand A, operand B, carry-in, expected sum, expected cout.
    logic [W-1:0] va [4] = '{16'h0000, 16'h8000, 16'h0F0F, 16'hABCD};
    logic [W-1:0] vb [4] = '{16'h0000, 16'h8000, 16'h00F1, 16'h1111};
    logic         vc [4] = '{1'b1,     1'b0,     1'b0,     1'b1};
    logic [W-1:0] vs [4] = '{16'h0001, 16'h0000, 16'h1000, 16'hBCDF};
    logic         vo [4] = '{1'b0,     1'b1,     1'b0,     1'b0};

    initial begin
        int wait_n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);

        // First start on the first edge with rst low; busy for exactly N cycles.
        rst = 1'b0;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        sb.push_back('{s: 16'h5555, c: 1'b0, cyc: cyc + 1 + N});
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("busy_run", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("busy_in_done", 32'(busy), 32'd0);

        // Full ripple cases with hand-computed results.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        sb.push_back('{s: 16'h0000, c: 1'b1, cyc: cyc + 1 + N});
        @(negedge clk); start = 1'b0;
        repeat (N - 1) @(negedge clk);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        sb.push_back('{s: 16'hFFFF, c: 1'b1, cyc: cyc + 1 + N});
        @(negedge clk); start = 1'b0;
        repeat (N) @(negedge clk);

        // Directed table, issued back-to-back.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; cin = vc[i]; start = 1'b1;
            sb.push_back('{s: vs[i], c: vo[i], cyc: cyc + 1 + N});
            @(negedge clk); start = 1'b0;
            repeat (N - 1) @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Start pulsed during RUN with new operands must be ignored.
        @(negedge clk);
        a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1; start = 1'b1;
        sb.push_back('{s: 16'h0000, c: 1'b1, cyc: cyc + 1 + N});
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (N + 2) @(negedge clk);

        // Reset in the second RUN cycle aborts with no done pulse.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        repeat (N + 4) @(negedge clk);

        // Start held high: one result every N+1 cycles.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{s: 16'h0100, c: 1'b0, cyc: cyc + 1 + N});
            repeat (N + 1) @(negedge clk);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Random operands against the reference sum, back-to-back.
        for (int i = 0; i < 10000; i++)
            op(W'($urandom), W'($urandom), 1'($urandom), N - 1);

        wait_n = 0;
        while (sb.size() != 0 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d results pending, expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
